// File: rtl/deslocamento_iterativo.sv
`default_nettype none
// ============================================================================
// Module      : deslocamento_iterativo
// Description : Multi-cycle shifter (SLL/SRL/SRA/ROR). A request is captured
//               in IDLE and then shifted by at most STEP bits per clock. The
//               result is held in DONE until the consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
module deslocamento_iterativo #(
    parameter int WIDTH = 64,
    parameter int STEP  = 8,
    localparam int NW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       shift,
    input  logic [WIDTH-1:0] entrada,
    input  logic [NW-1:0]    n,
    output logic [WIDTH-1:0] saida,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    // Shift-mode encoding
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // One extra bit so STEP == WIDTH is representable in the chunk compare
    localparam logic [NW:0] STEP_W  = (NW+1)'(STEP);
    localparam logic [NW:0] WIDTH_W = (NW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   work;
    logic [NW-1:0]      rem;
    logic               valid_q;
    logic               ready_q;
    logic               busy_q;

    logic [NW:0]        step_k;
    logic [NW:0]        rot_amt;
    logic [WIDTH-1:0]   next_work;

    // Chunk size k = min(STEP, remaining) and the working register after one chunk
    always_comb begin
        step_k    = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
        rot_amt   = WIDTH_W - step_k;
        next_work = work;
        case (mode)
            MODE_SLL: next_work = work << step_k;
            MODE_SRL: next_work = work >> step_k;
            MODE_SRA: next_work = $signed(work) >>> step_k;
            MODE_ROR: next_work = (work >> step_k) | (work << rot_amt);
            default:  next_work = work;
        endcase
    end

    // Control FSM with registered handshake outputs; flush overrides everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            mode    <= MODE_SLL;
            work    <= '0;
            rem     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            work    <= '0;
            rem     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode    <= shift;
                        work    <= entrada;
                        rem     <= n;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (n == '0) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    work <= next_work;
                    rem  <= rem - step_k[NW-1:0];
                    if ({1'b0, rem} == step_k) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // No accept on the release edge: in_ready only returns afterwards
                    if (out_ready) begin
                        state   <= IDLE;
                        work    <= '0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    work    <= '0;
                    rem     <= '0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    // The partially shifted working value never leaks out before the result is ready
    assign saida     = valid_q ? work : '0;

endmodule
`default_nettype wire
